qu_fetch: RTL and testbench

QU_FETCH -- requirements
Module: qu_fetch

---
 rtl/qu_common.sv | 23 ++
 rtl/qu_fetch_if.sv | 24 ++
 rtl/qu_fetch_fifo.sv | 51 +++++
 rtl/qu_fetch.sv | 79 +++++++
 tb/tb_qu_fetch.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/qu_common.sv
// Shared fetch-path types and constants for the qu core.
package qu_common;

  localparam int unsigned QU_PC_WIDTH    = 12;
  localparam int unsigned QU_INSTR_WIDTH = 32;
  localparam int unsigned QU_FETCH_DEPTH = 2;

  typedef logic [QU_INSTR_WIDTH-1:0] instr_t;
  typedef logic [QU_PC_WIDTH-1:0]    pc_t;

  localparam pc_t QU_PC_RESET_VAL = '0;

  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } fetch_entry_t;

  // Instructions are word aligned; low address bits are dropped.
  function automatic pc_t align_pc(pc_t pc);
    return {pc[QU_PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/qu_fetch_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and decode handshake.
interface qu_fetch_if;
  import qu_common::*;

  logic   imem_en;
  pc_t    imem_addr;
  instr_t imem_rdata;
  logic   redirect_valid;
  pc_t    redirect_pc;
  logic   instr_valid;
  logic   instr_ready;
  instr_t instr;
  pc_t    instr_pc;

  modport master (
    output imem_en, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_en, imem_addr, instr_valid, instr, instr_pc,
    output imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/qu_fetch_fifo.sv
// Small synchronous FIFO of fetched instructions with flush; head is read from registers.
module qu_fetch_fifo
  import qu_common::*;
#(
  parameter int unsigned Depth = QU_FETCH_DEPTH,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  fetch_entry_t      wdata,
  input  logic              pop,
  output fetch_entry_t      rdata,
  output logic              full,
  output logic              empty,
  output logic [CntW-1:0]   count
);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/qu_fetch.sv
// Instruction fetch stage: sequential PC, one-cycle memory latency, buffered hand-off to decode.
module qu_fetch
  import qu_common::*;
#(
  parameter int unsigned FIFO_DEPTH = QU_FETCH_DEPTH
) (
  input logic          clk,
  input logic          rst_n,
  qu_fetch_if.master   bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW:0] DepthLim = (CntW + 1)'(FIFO_DEPTH);

  pc_t             pc_q, pc_d, req_pc_q;
  logic            inflight_q, squash_q;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic [CntW:0]   occupancy;
  fetch_entry_t    fifo_wdata, head;
  logic            instr_valid, imem_en;

  always_comb begin
    instr_valid = !fifo_empty && !bus.redirect_valid;
    fifo_pop    = instr_valid && bus.instr_ready;
    fifo_push   = inflight_q && !squash_q && !bus.redirect_valid;
    // Slots committed next cycle: buffered + arriving - leaving; a new request needs one more.
    occupancy   = {1'b0, fifo_count} + (CntW + 1)'(inflight_q) - (CntW + 1)'(fifo_pop);
    imem_en     = rst_n && !bus.redirect_valid && (occupancy < DepthLim);
    pc_d        = pc_q;
    if (bus.redirect_valid) begin
      pc_d = align_pc(bus.redirect_pc);
    end else if (imem_en) begin
      pc_d = pc_q + QU_PC_WIDTH'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= QU_PC_RESET_VAL;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= imem_en;
      squash_q   <= bus.redirect_valid;
      if (imem_en) req_pc_q <= pc_q;
    end
  end

  assign fifo_wdata = '{pc: req_pc_q, instr: bus.imem_rdata};

  qu_fetch_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.redirect_valid),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Request throttling must guarantee a response always finds a free slot.
  no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && fifo_full && !fifo_pop));

  assign bus.imem_en     = imem_en;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = instr_valid;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;

endmodule

// File: tb/tb_qu_fetch.sv
// Directed bench for qu_fetch with a one-cycle-latency memory model returning tagged addresses.
module tb_qu_fetch;
  import qu_common::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  qu_fetch_if bus ();

  qu_fetch #(
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic instr_t mem_word(pc_t a);
    return 32'hC000_0000 | instr_t'(a);
  endfunction

  // Memory model: data for the address presented one cycle earlier.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= mem_word(bus.imem_addr);
    else             bus.imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic do_reset();
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advances to the next negedge where a transfer to decode takes place (bounded).
  task automatic next_delivery(output pc_t pc, output instr_t ins, output bit ok);
    ok  = 1'b0;
    pc  = '0;
    ins = '0;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      if (bus.instr_valid && bus.instr_ready) begin
        pc  = bus.instr_pc;
        ins = bus.instr;
        ok  = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (bus.imem_en !== 1'b0) begin
        n_fail++; $display("FAIL reset_imem_en: got %b want 0", bus.imem_en);
      end
      n_checks++;
      if (bus.instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_instr_valid: got %b want 0", bus.instr_valid);
      end
      n_checks++;
      if (bus.imem_addr !== QU_PC_RESET_VAL) begin
        n_fail++; $display("FAIL reset_imem_addr: got %h want %h", bus.imem_addr, QU_PC_RESET_VAL);
      end
      n_checks++;
      if (bus.instr !== '0 || bus.instr_pc !== '0) begin
        n_fail++; $display("FAIL reset_instr: got %h/%h want 0/0", bus.instr, bus.instr_pc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stream();
    bus.instr_ready = 1'b1;
    do_reset();
    #1;
    n_checks++;
    if (bus.imem_en !== 1'b1 || bus.imem_addr !== 12'h000) begin
      n_fail++; $display("FAIL stream_first_req: got en=%b addr=%h want en=1 addr=000",
                         bus.imem_en, bus.imem_addr);
    end
    @(negedge clk);
    n_checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 12'h004) begin
      n_fail++; $display("FAIL stream_cycle1: got valid=%b addr=%h want valid=0 addr=004",
                         bus.instr_valid, bus.imem_addr);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== pc_t'(4 * k) ||
          bus.instr !== mem_word(pc_t'(4 * k))) begin
        n_fail++; $display("FAIL stream_seq[%0d]: got valid=%b pc=%h instr=%h want pc=%h",
                           k, bus.instr_valid, bus.instr_pc, bus.instr, pc_t'(4 * k));
      end
    end
  endtask

  task automatic test_stall();
    int reqs = 0;
    int bad  = 0;
    pc_t pc; instr_t ins; bit ok;
    bus.instr_ready = 1'b0;
    do_reset();
    #1;
    for (int i = 0; i < 10; i++) begin
      if (bus.imem_en) reqs++;
      if (bus.instr_valid && bus.instr_pc !== 12'h000) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (reqs != 2) begin
      n_fail++; $display("FAIL stall_requests: got %0d want 2", reqs);
    end
    n_checks++;
    if (bad != 0 || bus.instr_valid !== 1'b1 || bus.instr_pc !== 12'h000) begin
      n_fail++; $display("FAIL stall_hold: got valid=%b pc=%h unstable=%0d want valid=1 pc=000",
                         bus.instr_valid, bus.instr_pc, bad);
    end
    n_checks++;
    if (bus.imem_en !== 1'b0) begin
      n_fail++; $display("FAIL stall_imem_en: got %b want 0", bus.imem_en);
    end
    bus.instr_ready = 1'b1;
    for (int k = 1; k < 6; k++) begin
      next_delivery(pc, ins, ok);
      n_checks++;
      if (!ok || pc !== pc_t'(4 * k) || ins !== mem_word(pc_t'(4 * k))) begin
        n_fail++; $display("FAIL stall_resume[%0d]: got ok=%b pc=%h instr=%h want pc=%h",
                           k, ok, pc, ins, pc_t'(4 * k));
      end
    end
  endtask

  task automatic test_redirect_full();
    pc_t pc; instr_t ins; bit ok;
    bus.instr_ready = 1'b0;
    do_reset();
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 12'h000 || bus.imem_en !== 1'b0) begin
      n_fail++; $display("FAIL redir_prefull: got valid=%b pc=%h en=%b want 1/000/0",
                         bus.instr_valid, bus.instr_pc, bus.imem_en);
    end
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 12'h103;
    #1;
    n_checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_en !== 1'b0) begin
      n_fail++; $display("FAIL redir_cycle: got valid=%b en=%b want 0/0",
                         bus.instr_valid, bus.imem_en);
    end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.imem_en !== 1'b1 || bus.imem_addr !== 12'h100 || bus.instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_first_req: got en=%b addr=%h valid=%b want 1/100/0",
                         bus.imem_en, bus.imem_addr, bus.instr_valid);
    end
    for (int k = 0; k < 3; k++) begin
      next_delivery(pc, ins, ok);
      n_checks++;
      if (!ok || pc !== pc_t'(12'h100 + 4 * k) || ins !== mem_word(pc_t'(12'h100 + 4 * k))) begin
        n_fail++; $display("FAIL redir_seq[%0d]: got ok=%b pc=%h instr=%h want pc=%h",
                           k, ok, pc, ins, pc_t'(12'h100 + 4 * k));
      end
    end
  endtask

  task automatic test_back_to_back();
    pc_t pc; instr_t ins; bit ok;
    bus.instr_ready = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 12'h200;
    @(negedge clk);
    bus.redirect_pc    = 12'h300;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      next_delivery(pc, ins, ok);
      n_checks++;
      if (!ok || pc !== pc_t'(12'h300 + 4 * k) || ins !== mem_word(pc_t'(12'h300 + 4 * k))) begin
        n_fail++; $display("FAIL b2b_seq[%0d]: got ok=%b pc=%h instr=%h want pc=%h",
                           k, ok, pc, ins, pc_t'(12'h300 + 4 * k));
      end
    end
  endtask

  task automatic test_wrap();
    pc_t pc; instr_t ins; bit ok;
    pc_t exp_pc [4];
    exp_pc[0] = 12'hFF8; exp_pc[1] = 12'hFFC; exp_pc[2] = 12'h000; exp_pc[3] = 12'h004;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 12'hFF8;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      next_delivery(pc, ins, ok);
      n_checks++;
      if (!ok || pc !== exp_pc[k] || ins !== mem_word(exp_pc[k])) begin
        n_fail++; $display("FAIL wrap_seq[%0d]: got ok=%b pc=%h instr=%h want pc=%h",
                           k, ok, pc, ins, exp_pc[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    pc_t pc; instr_t ins; bit ok;
    bus.instr_ready = 1'b0;
    do_reset();
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_prefull: got valid=%b want 1", bus.instr_valid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_en !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async: got valid=%b en=%b want 0/0",
                         bus.instr_valid, bus.imem_en);
    end
    n_checks++;
    if (bus.instr_pc !== '0 || bus.instr !== '0 || bus.imem_addr !== QU_PC_RESET_VAL) begin
      n_fail++; $display("FAIL rstmid_outputs: got pc=%h instr=%h addr=%h want 000/0/000",
                         bus.instr_pc, bus.instr, bus.imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      next_delivery(pc, ins, ok);
      n_checks++;
      if (!ok || pc !== pc_t'(4 * k) || ins !== mem_word(pc_t'(4 * k))) begin
        n_fail++; $display("FAIL rstmid_restart[%0d]: got ok=%b pc=%h instr=%h want pc=%h",
                           k, ok, pc, ins, pc_t'(4 * k));
      end
    end
  endtask

  initial begin
    n_checks           = 0;
    n_fail             = 0;
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
